ebi_bus_bridge: RTL and testbench
=================================

// Module: ebi_bus_bridge
// PURPOSE
//  Parametrised PowerPC EBI slave bridge; successor to the combinational strobe decoder.
//  Synchronises the asynchronous EBI strobes into clk and qualifies each access.
//  Issues single-cycle register read/write strobes with latched address, data and byte enables.
//  Returns read data with a programmable wait and a transfer-acknowledge pulse.
// PARAMETERS
//  ADDR_W       8   EBI address bits presented on ebi_addr
//  REG_AW       6   register address width; reg_addr = ebi_addr[ADDR_W-1 -: REG_AW]
//  DATA_W       32  EBI and register data width
//  BE_W         4   byte lanes = width of we_n (DATA_W/8)
//  SYNC_STAGES  2   synchroniser flops on cs_n, oe_n, we_n, rd_wr (>=2)
//  RD_WAIT      2   cycles from reg_re to read-data latch (1..15)
// PORTS
//  clk          in   1       system clock; single clock domain
//  rst          in   1       asynchronous, active-high reset
//  cs_n         in   1       EBI chip select, async, active low
//  oe_n         in   1       EBI output enable, async, active low
//  we_n         in   BE_W    EBI byte write enables, async, active low
//  rd_wr        in   1       EBI direction: 1 read, 0 write
//  ebi_addr     in   ADDR_W  EBI address (stable while cs_n low)
//  ebi_wdata    in   DATA_W  EBI write data
//  ebi_rdata    out  DATA_W  registered read data to EBI pads
//  ebi_rdata_oe out  1       pad output enable for ebi_rdata
//  ebi_ta_n     out  1       transfer acknowledge, active low, 1-cycle pulse
//  reg_addr     out  REG_AW  latched register address
//  reg_wdata    out  DATA_W  latched write data
//  reg_be       out  BE_W    latched byte enables (= ~we_n at qualification)
//  reg_we       out  1       1-cycle write strobe
//  reg_re       out  1       1-cycle read strobe
//  reg_rdata    in   DATA_W  register file read data
//  bus_err      out  1       1-cycle pulse on illegal strobe combination
// BEHAVIOUR
//  - Reset: FSM=IDLE, wait counter 0, synchronisers preset to inactive (cs_n/oe_n/we_n=1, rd_wr=1);
//    ebi_ta_n=1, ebi_rdata_oe=0, reg_we=reg_re=bus_err=0, ebi_rdata/reg_addr/reg_wdata/reg_be=0.
//  - All strobe decisions use synchronised copies (*_s); address/data sampled directly at latch time.
//  - FSM states: IDLE, QUAL, RWAIT, HOLD.
//  - IDLE: cs_s=0 -> QUAL. QUAL: cs_s=1 -> IDLE (glitch, no action); else decode:
//      write: rd_wr_s=0 & we_s!=all-ones -> reg_we=1 one cycle, latch addr/wdata, reg_be=~we_s,
//             ebi_ta_n=0 same cycle, -> HOLD.
//      read:  rd_wr_s=1 & we_s==all-ones -> reg_re=1 one cycle, latch addr, counter=RD_WAIT, -> RWAIT.
//      other combos -> bus_err=1 one cycle, no strobe, no ta, -> HOLD.
//  - Latency: reg_we/reg_re assert SYNC_STAGES+2 clk edges after cs_n first sampled low.
//  - RWAIT: counter decrements each cycle; at 1, ebi_rdata<=reg_rdata, ebi_ta_n=0 one cycle, -> HOLD.
//    cs_s=1 in RWAIT -> abort to IDLE: no ta, ebi_rdata unchanged, oe stays 0.
//  - HOLD: ebi_rdata_oe=1 iff access was a read and oe_s=0; cs_s=1 -> IDLE, oe=0 next cycle.
//  - Exactly one strobe per cs_n assertion; a held cs_n never re-triggers (HOLD required).
//  - Back-to-back: new access needs cs_s high >=1 cycle (IDLE) before QUAL.
//  - reg_addr/reg_wdata/reg_be hold last values between accesses.
//  - Reset mid-operation: immediate return to reset state; pending strobe/ta dropped.
// TESTING
//  1 Write: cs_n=0,rd_wr=0,we_n=4'b1100,addr=8'hA4,data=32'h12345678 -> one reg_we,
//    reg_addr=6'h29, reg_be=4'b0011, reg_wdata=32'h12345678, one ebi_ta_n low, no reg_re.
//  2 Read (RD_WAIT=2): cs_n=0,rd_wr=1,we_n=4'hF,addr=8'h10,reg_rdata=32'hCAFEF00D -> reg_re once,
//    2 cycles later ebi_rdata=32'hCAFEF00D and ta_n low 1 cycle; oe high while oe_n low.
//  3 Illegal: rd_wr=1 with we_n=4'b1110 -> bus_err 1 cycle, no reg_we/reg_re/ta.
//  4 Abort: drop cs_n during RWAIT -> FSM IDLE, no ta, ebi_rdata_oe stays 0.
//  5 cs_n held low 50 cycles for one write -> exactly one reg_we; back-to-back with 1-cycle gap
//    (post-sync) -> two strobes.
//  6 Assert rst during RWAIT -> all outputs to reset values same cycle; next access works normally.

Source files
------------

// File: rtl/ebi_bus_bridge_if.sv
// EBI pad-side and register-file-side signals of the bus bridge.
// slave: the bridge's view; master: the EBI/register-file environment driving it.
interface ebi_bus_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int REG_AW = 6,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic              cs_n;
  logic              oe_n;
  logic [BE_W-1:0]   we_n;
  logic              rd_wr;
  logic [ADDR_W-1:0] ebi_addr;
  logic [DATA_W-1:0] ebi_wdata;
  logic [DATA_W-1:0] ebi_rdata;
  logic              ebi_rdata_oe;
  logic              ebi_ta_n;
  logic [REG_AW-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [BE_W-1:0]   reg_be;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;
  logic              bus_err;

  modport slave (
    input  cs_n, oe_n, we_n, rd_wr, ebi_addr, ebi_wdata, reg_rdata,
    output ebi_rdata, ebi_rdata_oe, ebi_ta_n, reg_addr, reg_wdata, reg_be,
           reg_we, reg_re, bus_err
  );

  modport master (
    output cs_n, oe_n, we_n, rd_wr, ebi_addr, ebi_wdata, reg_rdata,
    input  ebi_rdata, ebi_rdata_oe, ebi_ta_n, reg_addr, reg_wdata, reg_be,
           reg_we, reg_re, bus_err
  );
endinterface

// File: rtl/ebi_bus_bridge.sv
// PowerPC EBI slave bridge: synchronises async strobes, issues one register strobe per cs_n
// assertion (SYNC_STAGES+2 edges after cs_n sampled low), reads return after RD_WAIT cycles with a TA pulse.
module ebi_bus_bridge #(
  parameter int ADDR_W      = 8,
  parameter int REG_AW      = 6,
  parameter int DATA_W      = 32,
  parameter int BE_W        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RD_WAIT     = 2
) (
  input  logic            clk,
  input  logic            rst,
  ebi_bus_bridge_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_QUAL  = 2'd1;
  localparam logic [1:0] ST_RWAIT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);

  // Synchroniser chains; stage 0 samples the pad, the last stage is the qualified copy.
  logic [SYNC_STAGES-1:0]           cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]           oe_sync_q, oe_sync_d;
  logic [SYNC_STAGES-1:0]           rd_wr_sync_q, rd_wr_sync_d;
  logic [SYNC_STAGES-1:0][BE_W-1:0] we_sync_q, we_sync_d;

  logic            cs_s, oe_s, rd_wr_s;
  logic [BE_W-1:0] we_s;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_acc_q, rd_acc_d;
  logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic [BE_W-1:0]   reg_be_q, reg_be_d;
  logic [DATA_W-1:0] ebi_rdata_q, ebi_rdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              bus_err_q, bus_err_d;
  logic              ebi_ta_n_q, ebi_ta_n_d;
  logic              ebi_rdata_oe_q, ebi_rdata_oe_d;

  always_comb begin
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
    oe_sync_d    = {oe_sync_q[SYNC_STAGES-2:0], bus.oe_n};
    rd_wr_sync_d = {rd_wr_sync_q[SYNC_STAGES-2:0], bus.rd_wr};
    we_sync_d    = {we_sync_q[SYNC_STAGES-2:0], bus.we_n};
  end

  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign oe_s    = oe_sync_q[SYNC_STAGES-1];
  assign rd_wr_s = rd_wr_sync_q[SYNC_STAGES-1];
  assign we_s    = we_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rd_acc_d       = rd_acc_q;
    reg_addr_d     = reg_addr_q;
    reg_wdata_d    = reg_wdata_q;
    reg_be_d       = reg_be_q;
    ebi_rdata_d    = ebi_rdata_q;
    reg_we_d       = 1'b0;
    reg_re_d       = 1'b0;
    bus_err_d      = 1'b0;
    ebi_ta_n_d     = 1'b1;
    ebi_rdata_oe_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!cs_s) state_d = ST_QUAL;
      end
      ST_QUAL: begin
        if (cs_s) begin
          state_d = ST_IDLE;
        end else if (!rd_wr_s && (we_s != {BE_W{1'b1}})) begin
          reg_we_d    = 1'b1;
          ebi_ta_n_d  = 1'b0;
          reg_addr_d  = bus.ebi_addr[ADDR_W-1 -: REG_AW];
          reg_wdata_d = bus.ebi_wdata;
          reg_be_d    = ~we_s;
          rd_acc_d    = 1'b0;
          state_d     = ST_HOLD;
        end else if (rd_wr_s && (we_s == {BE_W{1'b1}})) begin
          reg_re_d   = 1'b1;
          reg_addr_d = bus.ebi_addr[ADDR_W-1 -: REG_AW];
          cnt_d      = RD_WAIT_C;
          rd_acc_d   = 1'b1;
          state_d    = ST_RWAIT;
        end else begin
          bus_err_d = 1'b1;
          rd_acc_d  = 1'b0;
          state_d   = ST_HOLD;
        end
      end
      ST_RWAIT: begin
        // Abort wins over the data latch so a withdrawn read never acknowledges.
        if (cs_s) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd1) begin
          ebi_rdata_d    = bus.reg_rdata;
          ebi_ta_n_d     = 1'b0;
          ebi_rdata_oe_d = ~oe_s;
          cnt_d          = 4'd0;
          state_d        = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cs_s) state_d = ST_IDLE;
        else      ebi_rdata_oe_d = rd_acc_q & ~oe_s;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q      <= '1;
      oe_sync_q      <= '1;
      rd_wr_sync_q   <= '1;
      we_sync_q      <= '1;
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      rd_acc_q       <= 1'b0;
      reg_addr_q     <= '0;
      reg_wdata_q    <= '0;
      reg_be_q       <= '0;
      ebi_rdata_q    <= '0;
      reg_we_q       <= 1'b0;
      reg_re_q       <= 1'b0;
      bus_err_q      <= 1'b0;
      ebi_ta_n_q     <= 1'b1;
      ebi_rdata_oe_q <= 1'b0;
    end else begin
      cs_sync_q      <= cs_sync_d;
      oe_sync_q      <= oe_sync_d;
      rd_wr_sync_q   <= rd_wr_sync_d;
      we_sync_q      <= we_sync_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rd_acc_q       <= rd_acc_d;
      reg_addr_q     <= reg_addr_d;
      reg_wdata_q    <= reg_wdata_d;
      reg_be_q       <= reg_be_d;
      ebi_rdata_q    <= ebi_rdata_d;
      reg_we_q       <= reg_we_d;
      reg_re_q       <= reg_re_d;
      bus_err_q      <= bus_err_d;
      ebi_ta_n_q     <= ebi_ta_n_d;
      ebi_rdata_oe_q <= ebi_rdata_oe_d;
    end
  end

  assign bus.ebi_rdata    = ebi_rdata_q;
  assign bus.ebi_rdata_oe = ebi_rdata_oe_q;
  assign bus.ebi_ta_n     = ebi_ta_n_q;
  assign bus.reg_addr     = reg_addr_q;
  assign bus.reg_wdata    = reg_wdata_q;
  assign bus.reg_be       = reg_be_q;
  assign bus.reg_we       = reg_we_q;
  assign bus.reg_re       = reg_re_q;
  assign bus.bus_err      = bus_err_q;

endmodule

// File: tb/tb_ebi_bus_bridge.sv
// Directed bench for ebi_bus_bridge (SYNC_STAGES=2, RD_WAIT=2): write, read, illegal,
// abort, held/back-to-back cs_n and mid-read reset, with pulse counters sampled on negedge.
module tb_ebi_bus_bridge;
  localparam int ADDR_W = 8;
  localparam int REG_AW = 6;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ebi_bus_bridge_if #(.ADDR_W(ADDR_W), .REG_AW(REG_AW), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

  ebi_bus_bridge #(
    .ADDR_W(ADDR_W), .REG_AW(REG_AW), .DATA_W(DATA_W), .BE_W(BE_W),
    .SYNC_STAGES(2), .RD_WAIT(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Cycles-high counters for the 1-cycle pulses and the pad enable.
  int we_cnt = 0, re_cnt = 0, ta_cnt = 0, err_cnt = 0, oe_cnt = 0;
  always @(negedge clk) begin
    if (bus.reg_we === 1'b1)       we_cnt++;
    if (bus.reg_re === 1'b1)       re_cnt++;
    if (bus.ebi_ta_n === 1'b0)     ta_cnt++;
    if (bus.bus_err === 1'b1)      err_cnt++;
    if (bus.ebi_rdata_oe === 1'b1) oe_cnt++;
  end

  int we0, re0, ta0, err0, oe0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    we0 = we_cnt; re0 = re_cnt; ta0 = ta_cnt; err0 = err_cnt; oe0 = oe_cnt;
  endtask

  task automatic check_deltas(input string tag, input int we, input int re, input int ta,
                              input int err);
    check({tag, "_we_cnt"},  64'(we_cnt - we0),   64'(we));
    check({tag, "_re_cnt"},  64'(re_cnt - re0),   64'(re));
    check({tag, "_ta_cnt"},  64'(ta_cnt - ta0),   64'(ta));
    check({tag, "_err_cnt"}, 64'(err_cnt - err0), 64'(err));
  endtask

  task automatic idle_bus();
    bus.cs_n = 1'b1; bus.oe_n = 1'b1; bus.we_n = 4'hF; bus.rd_wr = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle_bus();
    bus.ebi_addr  = '0;
    bus.ebi_wdata = '0;
    bus.reg_rdata = '0;
    #2 rst = 1'b1;
    tick(2);
    check("rst_ta_n",  64'(bus.ebi_ta_n), 64'd1);
    check("rst_oe",    64'(bus.ebi_rdata_oe), 64'd0);
    check("rst_strb",  64'({bus.reg_we, bus.reg_re, bus.bus_err}), 64'd0);
    check("rst_rdata", 64'(bus.ebi_rdata), 64'd0);
    check("rst_latch", 64'({bus.reg_addr, bus.reg_be, bus.reg_wdata}), 64'd0);
    rst = 1'b0;
    tick(2);

    // 1: byte-lane write; strobe lands on the 4th edge after cs_n goes low
    snap();
    bus.ebi_addr = 8'hA4; bus.ebi_wdata = 32'h12345678; bus.we_n = 4'b1100;
    bus.rd_wr = 1'b0; bus.cs_n = 1'b0;
    tick(3);
    check("wr_early_we", 64'(bus.reg_we), 64'd0);
    tick(1);
    check("wr_we",    64'(bus.reg_we), 64'd1);
    check("wr_ta_n",  64'(bus.ebi_ta_n), 64'd0);
    check("wr_addr",  64'(bus.reg_addr), 64'h29);
    check("wr_be",    64'(bus.reg_be), 64'b0011);
    check("wr_wdata", 64'(bus.reg_wdata), 64'h12345678);
    tick(1);
    check("wr_we_drop", 64'({bus.reg_we, bus.ebi_ta_n}), 64'b01);
    tick(4);
    idle_bus();
    tick(4);
    check_deltas("wr", 1, 0, 1, 0);
    check("wr_oe_cnt", 64'(oe_cnt - oe0), 64'd0);

    // 2: read with oe_n low, data and TA two cycles after reg_re
    snap();
    bus.reg_rdata = 32'hCAFEF00D; bus.ebi_addr = 8'h10;
    bus.rd_wr = 1'b1; bus.we_n = 4'hF; bus.oe_n = 1'b0; bus.cs_n = 1'b0;
    tick(4);
    check("rd_re",    64'(bus.reg_re), 64'd1);
    check("rd_addr",  64'(bus.reg_addr), 64'h04);
    check("rd_hold_latch", 64'(bus.reg_wdata), 64'h12345678);
    tick(1);
    check("rd_wait_ta_n", 64'({bus.reg_re, bus.ebi_ta_n}), 64'b01);
    tick(1);
    check("rd_ta_n",  64'(bus.ebi_ta_n), 64'd0);
    check("rd_rdata", 64'(bus.ebi_rdata), 64'hCAFEF00D);
    tick(1);
    check("rd_ta_drop", 64'(bus.ebi_ta_n), 64'd1);
    check("rd_oe",      64'(bus.ebi_rdata_oe), 64'd1);
    bus.oe_n = 1'b1;
    tick(3);
    check("rd_oe_off",  64'(bus.ebi_rdata_oe), 64'd0);
    idle_bus();
    tick(4);
    check_deltas("rd", 0, 1, 1, 0);

    // 3: read direction with a byte write enable is illegal
    snap();
    bus.rd_wr = 1'b1; bus.we_n = 4'b1110; bus.cs_n = 1'b0;
    tick(4);
    check("err_pulse", 64'(bus.bus_err), 64'd1);
    tick(1);
    check("err_drop",  64'(bus.bus_err), 64'd0);
    tick(3);
    idle_bus();
    tick(4);
    check_deltas("err", 0, 0, 0, 1);

    // 4: cs_n withdrawn so cs_s rises while the read is waiting
    snap();
    bus.reg_rdata = 32'h0BADBEEF; bus.oe_n = 1'b0;
    bus.rd_wr = 1'b1; bus.we_n = 4'hF; bus.cs_n = 1'b0;
    tick(2);
    bus.cs_n = 1'b1;
    tick(6);
    check("abt_rdata", 64'(bus.ebi_rdata), 64'hCAFEF00D);
    check("abt_oe_cnt", 64'(oe_cnt - oe0), 64'd0);
    check("abt_state", 64'(dut.state_q), 64'd0);
    idle_bus();
    check_deltas("abt", 0, 1, 0, 0);

    // 5: one long write, then a second after a single-cycle gap
    snap();
    bus.ebi_addr = 8'h40; bus.ebi_wdata = 32'hA5A5A5A5;
    bus.rd_wr = 1'b0; bus.we_n = 4'b0000; bus.cs_n = 1'b0;
    tick(50);
    check_deltas("held", 1, 0, 1, 0);
    snap();
    bus.cs_n = 1'b1;
    tick(1);
    bus.cs_n = 1'b0; bus.ebi_addr = 8'hFC; bus.ebi_wdata = 32'hDEADBEEF; bus.we_n = 4'b0111;
    tick(10);
    idle_bus();
    tick(4);
    check_deltas("b2b", 1, 0, 1, 0);
    check("b2b_addr",  64'(bus.reg_addr), 64'h3F);
    check("b2b_be",    64'(bus.reg_be), 64'b1000);
    check("b2b_wdata", 64'(bus.reg_wdata), 64'hDEADBEEF);

    // 6: reset lands while a read is counting down
    snap();
    bus.reg_rdata = 32'h11223344; bus.ebi_addr = 8'h20;
    bus.rd_wr = 1'b1; bus.we_n = 4'hF; bus.oe_n = 1'b0; bus.cs_n = 1'b0;
    tick(5);
    rst = 1'b1;
    #1;
    check("mrst_ta_n",  64'(bus.ebi_ta_n), 64'd1);
    check("mrst_oe",    64'(bus.ebi_rdata_oe), 64'd0);
    check("mrst_rdata", 64'(bus.ebi_rdata), 64'd0);
    check("mrst_latch", 64'({bus.reg_addr, bus.reg_be, bus.reg_wdata}), 64'd0);
    idle_bus();
    tick(2);
    rst = 1'b0;
    tick(3);
    check_deltas("mrst", 0, 1, 0, 0);
    snap();
    bus.ebi_addr = 8'h08; bus.ebi_wdata = 32'h0F0F0F0F;
    bus.rd_wr = 1'b0; bus.we_n = 4'b1010; bus.cs_n = 1'b0;
    tick(4);
    check("post_we",    64'(bus.reg_we), 64'd1);
    check("post_be",    64'(bus.reg_be), 64'b0101);
    check("post_wdata", 64'(bus.reg_wdata), 64'h0F0F0F0F);
    idle_bus();
    tick(4);
    check_deltas("post", 1, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
